// File: rtl/sine_ctrl_pkg.sv
// Shared definitions for the sine sweep sequencer.
//   sweep_state_t  : sequencer state encoding
//   SETTLE_DEFAULT : default CORDIC pipeline latency in cycles
//   max_int        : elaboration-time helper used for counter sizing
package sine_ctrl_pkg;

  localparam int SETTLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DWELL,
    DONE
  } sweep_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sine_sweep_ctrl_if.sv
// Command/status bundle between the control register block (master) and the
// sweep sequencer (slave).
//   start/abort             : command strobes
//   f_start/f_stop/f_inc    : sweep frequency plan
//   dwell/phase_in          : valid cycles per tone, phase jump per tone
//   freq_step/phase_offset  : words driven to sine_generator
//   tone_valid/busy/done    : sequencer status
//   step_idx                : 0-based index of the tone being played
interface sine_sweep_ctrl_if #(
  parameter int WIDTH   = 24,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic [WIDTH-1:0]   f_start;
  logic [WIDTH-1:0]   f_stop;
  logic [WIDTH-1:0]   f_inc;
  logic [DWELL_W-1:0] dwell;
  logic [WIDTH-1:0]   phase_in;
  logic [WIDTH-1:0]   freq_step;
  logic [WIDTH-1:0]   phase_offset;
  logic               tone_valid;
  logic               busy;
  logic               done;
  logic [15:0]        step_idx;

  modport master (
    output start, abort, f_start, f_stop, f_inc, dwell, phase_in,
    input  freq_step, phase_offset, tone_valid, busy, done, step_idx
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_inc, dwell, phase_in,
    output freq_step, phase_offset, tone_valid, busy, done, step_idx
  );
endinterface

// File: rtl/sine_sweep_ctrl_tone_timer.sv
// Loadable down-counter shared by the SETTLE and DWELL phases.
//   clk, rst : clock, asynchronous active-high reset
//   load     : reload the counter with value (takes priority over counting)
//   value    : number of cycles the next phase lasts (>= 1)
//   expire   : high during the last cycle of the loaded phase
module tone_timer
  import sine_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A phase loaded with N runs N cycles; the count reads 1 on the last one.
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for sine_generator.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of sine_sweep_ctrl_if (commands in, generator
//              words and status out)
// Plays f_start, f_start+f_inc, ... clamped to f_stop. Each tone waits SETTLE
// cycles for the CORDIC pipeline, then holds tone_valid for max(dwell,1).
module sine_sweep_ctrl
  import sine_ctrl_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int DWELL_W = 16,
  parameter int SETTLE  = SETTLE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  sine_sweep_ctrl_if.slave   bus
);

  localparam int TW = max_int(DWELL_W, $clog2(SETTLE + 1));
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE);

  sweep_state_t       state, state_nx;
  logic [WIDTH-1:0]   freq_q, freq_nx;
  logic [WIDTH-1:0]   stop_q, inc_q, phase_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [15:0]        idx_q, idx_nx;
  logic               accept;
  logic               tmr_load, tmr_expire;
  logic [TW-1:0]      tmr_value;
  logic [WIDTH:0]     sum_wide;
  logic [WIDTH-1:0]   freq_clamped;
  logic               last_tone;
  logic               active_nx, new_tone;

  logic [WIDTH-1:0]   freq_step_q, phase_offset_q;
  logic               tone_valid_q, busy_q, done_q;

  tone_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // One extra bit keeps freq+inc from wrapping before the clamp.
  assign sum_wide     = {1'b0, freq_q} + {1'b0, inc_q};
  assign freq_clamped = (sum_wide >= {1'b0, stop_q}) ? stop_q : sum_wide[WIDTH-1:0];
  assign last_tone    = (inc_q == '0) || (freq_q >= stop_q);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_nx  = state;
    freq_nx   = freq_q;
    idx_nx    = idx_q;
    accept    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = SETTLE_LOAD;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx = sine_ctrl_pkg::SETTLE;
          accept   = 1'b1;
          tmr_load = 1'b1;
          freq_nx  = bus.f_start;
          idx_nx   = '0;
        end
      end
      sine_ctrl_pkg::SETTLE: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (tmr_expire) begin
          state_nx  = DWELL;
          tmr_load  = 1'b1;
          tmr_value = (dwell_q == '0) ? TW'(1) : TW'(dwell_q);
        end
      end
      DWELL: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (tmr_expire) begin
          if (last_tone) begin
            state_nx = DONE;
          end else begin
            state_nx = sine_ctrl_pkg::SETTLE;
            tmr_load = 1'b1;
            freq_nx  = freq_clamped;
            idx_nx   = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx == IDLE) idx_nx = '0;
  end

  assign active_nx = (state_nx == sine_ctrl_pkg::SETTLE) || (state_nx == DWELL);
  // First SETTLE cycle of a tone: entering SETTLE from IDLE or DWELL.
  assign new_tone  = (state_nx == sine_ctrl_pkg::SETTLE) && (state != sine_ctrl_pkg::SETTLE);

  // Outputs are flopped from next-state values so they line up with the
  // state they describe and carry no combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      freq_q         <= '0;
      idx_q          <= '0;
      stop_q         <= '0;
      inc_q          <= '0;
      dwell_q        <= '0;
      phase_q        <= '0;
      freq_step_q    <= '0;
      phase_offset_q <= '0;
      tone_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state  <= state_nx;
      freq_q <= freq_nx;
      idx_q  <= idx_nx;
      if (accept) begin
        stop_q  <= bus.f_stop;
        inc_q   <= bus.f_inc;
        dwell_q <= bus.dwell;
        phase_q <= bus.phase_in;
      end
      busy_q         <= active_nx;
      tone_valid_q   <= (state_nx == DWELL);
      done_q         <= (state_nx == DONE);
      freq_step_q    <= active_nx ? freq_nx : '0;
      phase_offset_q <= new_tone ? (accept ? bus.phase_in : phase_q) : '0;
    end
  end

  assign bus.freq_step    = freq_step_q;
  assign bus.phase_offset = phase_offset_q;
  assign bus.tone_valid   = tone_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.step_idx     = idx_q;

endmodule
